// File: rtl/branch_predictor_pipe.sv
// Direct-mapped BTB/BHT with valid-bit clear sequencer and an execute-side update pipe.
// Optional gshare index hashing is compiled in with BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned LOG_ENTRIES = 10,
  parameter int unsigned HIST_BITS   = 2,
  parameter int unsigned PIPE_DEPTH  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            flush,
  output logic            busy,
  input  logic            executing_branch_active,
  input  logic [XLEN-1:0] executing_branch_pc,
  input  logic [XLEN-1:0] executing_branch_target,
  input  logic            executing_branch_taken,
  input  logic [XLEN-1:0] incoming_instruction_pc,
  output logic            predicted_jump_target_taken,
  output logic [XLEN-1:0] predicted_jump_target
);

  localparam int unsigned TAG_BITS = XLEN - LOG_ENTRIES - 2;
  localparam int unsigned ENTRIES  = 1 << LOG_ENTRIES;
  localparam int unsigned LAST     = PIPE_DEPTH - 1;

  localparam logic [HIST_BITS-1:0]   CTR_MAX        = '1;
  localparam logic [HIST_BITS-1:0]   CTR_WEAK_TAKEN = HIST_BITS'(1 << (HIST_BITS - 1));
  localparam logic [HIST_BITS-1:0]   CTR_WEAK_NOT   = HIST_BITS'((1 << (HIST_BITS - 1)) - 1);
  localparam logic [LOG_ENTRIES-1:0] LAST_IDX       = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Prediction table; valid bits are cleared by the sequencer, the rest never needs reset
  logic [ENTRIES-1:0]  valid_mem;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];
  logic [HIST_BITS-1:0] ctr_mem   [ENTRIES];

  state_t                 state_q, state_d;
  logic [LOG_ENTRIES-1:0] clear_idx_q, clear_idx_d;

  // Fetch-read register
  logic                   f_valid;
  logic [TAG_BITS-1:0]    f_tag;
  logic [HIST_BITS-1:0]   f_ctr;
  logic [LOG_ENTRIES-1:0] f_idx;
  logic                   f_hit;
  logic [XLEN-1:0]        f_target;
  logic                   pred_taken_q;

  // Fetch-to-execute pipe; the target is not carried since the update overwrites it
  logic                   p_valid [PIPE_DEPTH];
  logic [TAG_BITS-1:0]    p_tag   [PIPE_DEPTH];
  logic [HIST_BITS-1:0]   p_ctr   [PIPE_DEPTH];
  logic [LOG_ENTRIES-1:0] p_idx   [PIPE_DEPTH];
  logic                   p_hit   [PIPE_DEPTH];

  logic [LOG_ENTRIES-1:0] fetch_idx_c;
  logic [TAG_BITS-1:0]    fetch_tag_c;
  logic                   read_hit_c;
  logic [TAG_BITS-1:0]    exec_tag_c;
  logic                   orig_hit_c;
  logic                   upd_accept_c;
  logic [HIST_BITS-1:0]   new_ctr_c;

  assign fetch_tag_c = incoming_instruction_pc[XLEN-1:LOG_ENTRIES+2];
  assign exec_tag_c  = executing_branch_pc[XLEN-1:LOG_ENTRIES+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [LOG_ENTRIES-1:0] ghr;

  assign fetch_idx_c = incoming_instruction_pc[LOG_ENTRIES+1:2] ^ ghr;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      ghr <= '0;
    end else if (upd_accept_c) begin
      ghr <= {ghr[LOG_ENTRIES-2:0], executing_branch_taken};
    end
  end
`else
  assign fetch_idx_c = incoming_instruction_pc[LOG_ENTRIES+1:2];
`endif

  assign busy       = (state_q == ST_CLEAR);
  assign read_hit_c = valid_mem[fetch_idx_c] && (tag_mem[fetch_idx_c] == fetch_tag_c);

  // Clear sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  // Clear sequencer next state; a flush at any time restarts from index 0
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d     = ST_CLEAR;
          clear_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        if (flush) begin
          clear_idx_d = '0;
        end else if (clear_idx_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + LOG_ENTRIES'(1);
        end
      end
      default: ;
    endcase
  end

  // Fetch register, pipe and registered prediction
  always_ff @(posedge clock) begin
    if (reset) begin
      f_valid      <= 1'b0;
      f_tag        <= '0;
      f_ctr        <= '0;
      f_idx        <= '0;
      f_hit        <= 1'b0;
      f_target     <= '0;
      pred_taken_q <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        p_valid[i] <= 1'b0;
        p_tag[i]   <= '0;
        p_ctr[i]   <= '0;
        p_idx[i]   <= '0;
        p_hit[i]   <= 1'b0;
      end
    end else begin
      if (enable) begin
        f_valid    <= valid_mem[fetch_idx_c];
        f_tag      <= tag_mem[fetch_idx_c];
        f_ctr      <= ctr_mem[fetch_idx_c];
        f_idx      <= fetch_idx_c;
        f_hit      <= read_hit_c;
        f_target   <= target_mem[fetch_idx_c];
        p_valid[0] <= f_valid;
        p_tag[0]   <= f_tag;
        p_ctr[0]   <= f_ctr;
        p_idx[0]   <= f_idx;
        p_hit[0]   <= f_hit;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          p_valid[i] <= p_valid[i-1];
          p_tag[i]   <= p_tag[i-1];
          p_ctr[i]   <= p_ctr[i-1];
          p_idx[i]   <= p_idx[i-1];
          p_hit[i]   <= p_hit[i-1];
        end
      end
      if (state_d == ST_CLEAR) begin
        pred_taken_q <= 1'b0;
      end else if (enable) begin
        pred_taken_q <= read_hit_c && ctr_mem[fetch_idx_c][HIST_BITS-1];
      end
    end
  end

  assign predicted_jump_target_taken = pred_taken_q;
  assign predicted_jump_target       = f_target;

  // Hit is re-checked against the executing PC rather than reusing the fetch-time flag
  assign orig_hit_c   = p_valid[LAST] && (p_tag[LAST] == exec_tag_c);
  assign upd_accept_c = executing_branch_active && enable && !busy;

  always_comb begin
    new_ctr_c = executing_branch_taken ? CTR_WEAK_TAKEN : CTR_WEAK_NOT;
    if (orig_hit_c) begin
      if (executing_branch_taken) begin
        new_ctr_c = (p_ctr[LAST] == CTR_MAX) ? CTR_MAX : p_ctr[LAST] + HIST_BITS'(1);
      end else begin
        new_ctr_c = (p_ctr[LAST] == '0) ? '0 : p_ctr[LAST] - HIST_BITS'(1);
      end
    end
  end

  // Table write port: clearing takes priority and ignores enable
  always_ff @(posedge clock) begin
    if (busy) begin
      valid_mem[clear_idx_q] <= 1'b0;
    end else if (upd_accept_c) begin
      valid_mem[p_idx[LAST]]  <= 1'b1;
      tag_mem[p_idx[LAST]]    <= exec_tag_c;
      target_mem[p_idx[LAST]] <= executing_branch_target;
      ctr_mem[p_idx[LAST]]    <= new_ctr_c;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{incoming_instruction_pc[1:0], executing_branch_pc[LOG_ENTRIES+1:0],
                         p_hit[LAST]};

endmodule

// File: tb/tb_branch_predictor_pipe.sv
// Bench for branch_predictor_pipe: directed scenarios plus randomized traffic against a
// transaction-level table model. Define BRANCH_PREDICTOR_GSHARE_EN for the gshare build.
module tb_branch_predictor_pipe;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned LOG_ENTRIES = 4;
  localparam int unsigned HIST_BITS   = 2;
  localparam int unsigned PIPE_DEPTH  = 2;
  localparam int unsigned ENTRIES     = 1 << LOG_ENTRIES;

  logic            clock = 1'b0;
  logic            reset, enable, flush, busy;
  logic            executing_branch_active, executing_branch_taken;
  logic [XLEN-1:0] executing_branch_pc, executing_branch_target, incoming_instruction_pc;
  logic            predicted_jump_target_taken;
  logic [XLEN-1:0] predicted_jump_target;

  always #5 clock = ~clock;

  branch_predictor_pipe #(
    .XLEN(XLEN), .LOG_ENTRIES(LOG_ENTRIES), .HIST_BITS(HIST_BITS), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .enable                     (enable),
    .flush                      (flush),
    .busy                       (busy),
    .executing_branch_active    (executing_branch_active),
    .executing_branch_pc        (executing_branch_pc),
    .executing_branch_target    (executing_branch_target),
    .executing_branch_taken     (executing_branch_taken),
    .incoming_instruction_pc    (incoming_instruction_pc),
    .predicted_jump_target_taken(predicted_jump_target_taken),
    .predicted_jump_target      (predicted_jump_target)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the table, the snapshots read at fetch time, and the clear progress
  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          ctr;
    int          idx;
    bit          known;
  } snap_t;

  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          m_known  [ENTRIES];
  snap_t       m_pipe   [PIPE_DEPTH+1];
  bit          m_busy = 1'b0;
  int          m_clr = 0;
  int          m_ghr = 0;
  bit          m_taken = 1'b0;
  logic [31:0] m_tgt_out = '0;
  bit          m_tgt_known = 1'b1;

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (LOG_ENTRIES + 2);
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % ENTRIES);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  // Advance one clock: sample the driven inputs, step the model, settle 1 time unit later
  task automatic cycle();
    bit r, en, fl, act, tk, hit, acc, nb;
    logic [31:0] epc, etgt, ipc;
    snap_t rd, orig;
    int ri, nc, nclr;
    r = reset; en = enable; fl = flush; act = executing_branch_active;
    tk = executing_branch_taken; epc = executing_branch_pc; etgt = executing_branch_target;
    ipc = incoming_instruction_pc;
    @(posedge clock);
    ri = idx_of(ipc);
    rd.valid = m_valid[ri]; rd.tag = m_tag[ri]; rd.target = m_target[ri];
    rd.ctr = m_ctr[ri]; rd.idx = ri; rd.known = m_known[ri];
    orig = m_pipe[PIPE_DEPTH];
    acc = !m_busy && act && en;
    if (m_busy) begin
      m_valid[m_clr] = 1'b0;
    end else if (acc) begin
      hit = orig.valid && (orig.tag == tag_of(epc));
      if (hit) nc = tk ? ((orig.ctr == (1 << HIST_BITS) - 1) ? orig.ctr : orig.ctr + 1)
                       : ((orig.ctr == 0) ? 0 : orig.ctr - 1);
      else     nc = tk ? (1 << (HIST_BITS - 1)) : (1 << (HIST_BITS - 1)) - 1;
      m_valid[orig.idx] = 1'b1; m_tag[orig.idx] = tag_of(epc);
      m_target[orig.idx] = etgt; m_ctr[orig.idx] = nc; m_known[orig.idx] = 1'b1;
    end
    if (r || fl) m_ghr = 0;
    else if (acc) m_ghr = ((m_ghr << 1) | int'(tk)) % ENTRIES;
    nb = m_busy; nclr = m_clr;
    if (r || fl) begin
      nb = 1'b1; nclr = 0;
    end else if (m_busy) begin
      if (m_clr == ENTRIES - 1) begin nb = 1'b0; nclr = 0; end
      else nclr = m_clr + 1;
    end
    if (r) begin
      for (int i = 0; i <= PIPE_DEPTH; i++) begin
        m_pipe[i].valid = 1'b0; m_pipe[i].tag = 0; m_pipe[i].target = '0;
        m_pipe[i].ctr = 0; m_pipe[i].idx = 0; m_pipe[i].known = 1'b1;
      end
      m_taken = 1'b0; m_tgt_out = '0; m_tgt_known = 1'b1;
    end else begin
      if (en) begin
        for (int i = PIPE_DEPTH; i >= 1; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = rd;
        m_tgt_out = rd.target; m_tgt_known = rd.known;
      end
      if (nb) m_taken = 1'b0;
      else if (en) m_taken = rd.valid && (rd.tag == tag_of(ipc)) && (rd.ctr >= (1 << (HIST_BITS - 1)));
    end
    m_busy = nb; m_clr = nclr;
    #1;
  endtask

  task automatic run_branch(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    incoming_instruction_pc = pc;
    cycle();
    incoming_instruction_pc = 32'h4;
    repeat (PIPE_DEPTH) cycle();
    executing_branch_active = 1'b1; executing_branch_pc = pc;
    executing_branch_target = tgt;  executing_branch_taken = tk;
    cycle();
    executing_branch_active = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    incoming_instruction_pc = pc;
    cycle();
  endtask

  task automatic reset_and_clear();
    reset = 1'b1; enable = 1'b1; flush = 1'b0; executing_branch_active = 1'b0;
    incoming_instruction_pc = 32'h40;
    repeat (2) cycle();
    reset = 1'b0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) cycle();
    repeat (PIPE_DEPTH + 2) cycle();
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; enable = 1'b1; flush = 1'b0; executing_branch_active = 1'b0;
    executing_branch_pc = '0; executing_branch_target = '0; executing_branch_taken = 1'b0;
    incoming_instruction_pc = 32'h40;
    repeat (2) cycle();
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_taken: got %b want 0", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h0) begin
      n_fail++; $display("FAIL reset_target: got %h want 0", predicted_jump_target);
    end
    reset = 1'b0;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      n_checks++;
      if (predicted_jump_target_taken !== 1'b0) begin
        n_fail++; $display("FAIL clear_taken: got %b want 0", predicted_jump_target_taken);
      end
      if (busy !== 1'b1) break;
      cnt++;
    end
    n_checks++;
    if (cnt != ENTRIES) begin n_fail++; $display("FAIL clear_len: got %0d want %0d", cnt, ENTRIES); end
    repeat (PIPE_DEPTH + 2) cycle();
  endtask

  task automatic test_train_miss();
    run_branch(32'h40, 32'h100, 1'b1);
    fetch(32'h40);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL miss_taken: got %b want 1", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h100) begin
      n_fail++; $display("FAIL miss_target: got %h want 100", predicted_jump_target);
    end
  endtask

  task automatic test_saturation();
    bit exp_tk [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit dir    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_branch(32'h40, 32'h100, dir[i]);
      fetch(32'h40);
      n_checks++;
      if (predicted_jump_target_taken !== exp_tk[i]) begin
        n_fail++;
        $display("FAIL sat_step%0d: got %b want %b", i, predicted_jump_target_taken, exp_tk[i]);
      end
    end
  endtask

  task automatic test_tag_alias();
    fetch(32'h440);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL alias_taken: got %b want 0", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h100) begin
      n_fail++; $display("FAIL alias_target: got %h want 100", predicted_jump_target);
    end
    run_branch(32'h440, 32'h200, 1'b0);
    fetch(32'h440);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL replace_taken: got %b want 0", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h200) begin
      n_fail++; $display("FAIL replace_target: got %h want 200", predicted_jump_target);
    end
    run_branch(32'h440, 32'h200, 1'b1);
    fetch(32'h440);
    n_checks++;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL replace_ctr: got %b want 1", predicted_jump_target_taken);
    end
    fetch(32'h40);
    n_checks++;
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL old_tag_gone: got %b want 0", predicted_jump_target_taken);
    end
  endtask

  task automatic test_stall();
    fetch(32'h440);
    enable = 1'b0; executing_branch_active = 1'b1; executing_branch_pc = 32'h440;
    executing_branch_target = 32'hdead0000; executing_branch_taken = 1'b0;
    incoming_instruction_pc = 32'h80;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks += 2;
      if (predicted_jump_target_taken !== 1'b1) begin
        n_fail++; $display("FAIL stall_taken%0d: got %b want 1", i, predicted_jump_target_taken);
      end
      if (predicted_jump_target !== 32'h200) begin
        n_fail++; $display("FAIL stall_target%0d: got %h want 200", i, predicted_jump_target);
      end
    end
    enable = 1'b1; executing_branch_active = 1'b0; incoming_instruction_pc = 32'h4;
    repeat (PIPE_DEPTH) cycle();
    executing_branch_active = 1'b1; executing_branch_pc = 32'h440;
    executing_branch_target = 32'h200; executing_branch_taken = 1'b1;
    cycle();
    executing_branch_active = 1'b0;
    run_branch(32'h440, 32'h200, 1'b0);
    fetch(32'h440);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL stall_pipe_hold: got %b want 1", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h200) begin
      n_fail++; $display("FAIL stall_no_write: got %h want 200", predicted_jump_target);
    end
  endtask

  task automatic test_flush();
    int cnt;
    run_branch(32'h40, 32'h100, 1'b1);
    fetch(32'h40);
    n_checks++;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL preflush_taken: got %b want 1", predicted_jump_target_taken);
    end
    flush = 1'b1; cycle(); flush = 1'b0;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      executing_branch_active = (cnt == 3); executing_branch_pc = 32'h40;
      executing_branch_target = 32'h100; executing_branch_taken = 1'b1;
      cycle();
      n_checks++;
      if (predicted_jump_target_taken !== 1'b0) begin
        n_fail++; $display("FAIL flush_taken: got %b want 0", predicted_jump_target_taken);
      end
      if (busy !== 1'b1) break;
      cnt++;
    end
    executing_branch_active = 1'b0;
    n_checks++;
    if (cnt != ENTRIES) begin n_fail++; $display("FAIL flush_len: got %0d want %0d", cnt, ENTRIES); end
    repeat (PIPE_DEPTH + 1) cycle();
    fetch(32'h40);
    n_checks++;
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL postflush_taken: got %b want 0", predicted_jump_target_taken);
    end
  endtask

  task automatic test_clear_restart(input bit use_reset);
    int cnt;
    flush = 1'b1; cycle(); flush = 1'b0;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      if (cnt == 5) begin
        if (use_reset) reset = 1'b1; else flush = 1'b1;
      end
      cycle();
      reset = 1'b0; flush = 1'b0;
      if (busy !== 1'b1) break;
      cnt++;
    end
    n_checks++;
    if (cnt != ENTRIES + 5) begin
      n_fail++; $display("FAIL restart_len(reset=%0d): got %0d want %0d", use_reset, cnt, ENTRIES + 5);
    end
    repeat (PIPE_DEPTH + 2) cycle();
  endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  task automatic test_gshare();
    reset_and_clear();
    run_branch(32'h40, 32'h100, 1'b1);
    fetch(32'h40);
    n_checks++;
    if (predicted_jump_target_taken !== 1'b0) begin
      n_fail++; $display("FAIL gshare_idx1_empty: got %b want 0", predicted_jump_target_taken);
    end
    fetch(32'h44);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL gshare_xor_taken: got %b want 1", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h100) begin
      n_fail++; $display("FAIL gshare_xor_target: got %h want 100", predicted_jump_target);
    end
    run_branch(32'h40, 32'h300, 1'b1);
    fetch(32'h48);
    n_checks += 2;
    if (predicted_jump_target_taken !== 1'b1) begin
      n_fail++; $display("FAIL gshare_upd_taken: got %b want 1", predicted_jump_target_taken);
    end
    if (predicted_jump_target !== 32'h300) begin
      n_fail++; $display("FAIL gshare_upd_target: got %h want 300", predicted_jump_target);
    end
  endtask
`endif

  function automatic logic [31:0] rand_pc();
    return ((32'($urandom) % 2) << 6) | ((32'($urandom) % 4) << 2) | (32'($urandom) % 4);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      enable                  = ($urandom % 8) != 0;
      flush                   = ($urandom % 96) == 0;
      executing_branch_active = ($urandom % 3) == 0;
      executing_branch_pc     = rand_pc();
      executing_branch_target = 32'($urandom) & 32'hffff_fffc;
      executing_branch_taken  = 1'($urandom % 2);
      incoming_instruction_pc = rand_pc();
      cycle();
      n_checks += 2;
      if (busy !== m_busy) begin
        n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, m_busy);
      end
      if (predicted_jump_target_taken !== m_taken) begin
        n_fail++; $display("FAIL rnd_taken@%0d: got %b want %b", i, predicted_jump_target_taken, m_taken);
      end
      if (m_tgt_known) begin
        n_checks++;
        if (predicted_jump_target !== m_tgt_out) begin
          n_fail++; $display("FAIL rnd_target@%0d: got %h want %h", i, predicted_jump_target, m_tgt_out);
        end
      end
    end
    flush = 1'b0; executing_branch_active = 1'b0; enable = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 0; m_known[i] = 1'b0;
    end
    for (int i = 0; i <= PIPE_DEPTH; i++) begin
      m_pipe[i].valid = 1'b0; m_pipe[i].tag = 0; m_pipe[i].target = '0;
      m_pipe[i].ctr = 0; m_pipe[i].idx = 0; m_pipe[i].known = 1'b0;
    end
    test_reset();
    test_train_miss();
    test_saturation();
    test_tag_alias();
    test_stall();
    test_flush();
    test_clear_restart(1'b0);
    test_clear_restart(1'b1);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
